serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract engine built around the team's 1-bit full adder/subtractor cell (`fas1bit`). It accepts two WIDTH-bit operands and an operation select. It presents the operands to the cell one bit per clock, LSB first, with the carry fed back through a register. It returns the assembled WIDTH-bit result with carry-out and signed-overflow flags. It sits directly upstream of `fas1bit`, driving `a`, `b`, `s_op` and `cin`, and directly downstream of it, consuming `s` and `cout`.

---
 rtl/serial_addsub_ctrl_if.sv | 25 ++
 rtl/serial_addsub_ctrl.sv | 160 ++++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_ctrl_if.sv
// Request/result bundle for the bit-serial add/subtract engine.
// The master side issues start/op/a/b and receives busy/done/result/flags.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract engine: feeds operands LSB-first through a
// 1-bit full adder/subtractor cell with a registered carry, then presents
// the assembled result with carry-out and signed-overflow flags.

// 1-bit full adder/subtractor cell; s_op inverts b for subtraction.
module fas1bit (
  input  logic a,
  input  logic b,
  input  logic s_op,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic bx;
  assign bx   = b ^ s_op;
  assign s    = a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_addsub_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             c_msb_in_q, c_msb_in_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;

  logic             cell_s;
  logic             cell_cout;
  logic [WIDTH-1:0] r_shift;

  fas1bit u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .s_op (op_q),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // Result register after absorbing this cycle's sum bit at the MSB.
  assign r_shift = {cell_s, r_sr_q[WIDTH-1:1]};

  // Next-state, datapath updates and registered outputs.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    op_d       = op_q;
    result_d   = result_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    c_msb_in_d = c_msb_in_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    r_sr_d     = r_sr_q;

    unique case (state_q)
      RUN: begin
        r_sr_d  = r_shift;
        carry_d = cell_cout;
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB; cell_cout is the one out of it.
          c_msb_in_d = carry_q;
          result_d   = r_shift;
          cout_d     = cell_cout;
          ovf_d      = carry_q ^ cell_cout;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE.
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          op_d    = bus.op;
          carry_d = bus.op;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      op_q       <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      c_msb_in_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      op_q       <= op_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      c_msb_in_q <= c_msb_in_d;
    end
  end

  // Operand and partial-result shift registers; fully reloaded/overwritten per operation.
  always_ff @(posedge clk) begin
    a_sr_q <= a_sr_d;
    b_sr_q <= b_sr_d;
    r_sr_q <= r_sr_d;
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed and randomized bench for serial_addsub_ctrl (WIDTH=8).
module tb_serial_addsub_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nerr = 0;
  int   nchk = 0;

  serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, ovf, result} from integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic o);
    int ux, uy, sx, sy, exact_s, exact_u;
    logic c, v;
    logic [W-1:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!o) begin
      exact_u = ux + uy;
      exact_s = sx + sy;
      c = (exact_u >= (1 << W));
    end else begin
      exact_u = ux - uy;
      exact_s = sx - sy;
      c = (ux >= uy);
    end
    r = exact_u[W-1:0];
    v = (exact_s > ((1 << (W-1)) - 1)) || (exact_s < -(1 << (W-1)));
    return {c, v, r};
  endfunction

  // One full operation: start, W RUN cycles, then the done cycle.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop,
                       input string tag, input bit scramble, input bit go_idle);
    logic [W+1:0] e;
    bit bad_run;
    e = model(ia, ib, iop);
    bus.a = ia; bus.b = ib; bus.op = iop; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bad_run = 1'b0;
    for (int k = 1; k < W; k++) begin
      if (!(bus.busy === 1'b1 && bus.done === 1'b0)) bad_run = 1'b1;
      if (scramble) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 1'($urandom);
      end
      tick();
    end
    if (!(bus.busy === 1'b1 && bus.done === 1'b0)) bad_run = 1'b1;
    check({tag, "_busy_run"}, 32'(bad_run), 32'd0);
    tick();
    check({tag, "_done"}, {30'd0, bus.busy, bus.done}, 32'b01);
    check({tag, "_res"}, {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, e});
    if (go_idle) begin
      tick();
      check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [W+1:0] e;
    int dcount;
    int busy_low;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;

    // Reset state
    tick(); tick();
    check("rst_outs", {21'd0, bus.busy, bus.done, bus.cout, bus.ovf, bus.result}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_outs", {21'd0, bus.busy, bus.done, bus.cout, bus.ovf, bus.result}, 32'd0);

    // Directed add/subtract corners
    do_op(8'h35, 8'h4A, 1'b0, "add_35_4a", 1'b0, 1'b1);
    check("add_35_4a_abs", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b00, 8'h7F});
    do_op(8'hFF, 8'h01, 1'b0, "add_ff_01", 1'b0, 1'b1);
    check("add_ff_01_abs", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b10, 8'h00});
    do_op(8'h7F, 8'h01, 1'b0, "add_7f_01", 1'b0, 1'b1);
    check("add_7f_01_abs", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b01, 8'h80});
    do_op(8'h10, 8'h20, 1'b1, "sub_10_20", 1'b0, 1'b1);
    check("sub_10_20_abs", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b00, 8'hF0});
    do_op(8'h80, 8'h01, 1'b1, "sub_80_01", 1'b0, 1'b1);
    check("sub_80_01_abs", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b11, 8'h7F});
    do_op(8'h55, 8'h55, 1'b1, "sub_55_55", 1'b0, 1'b1);
    check("sub_55_55_abs", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b10, 8'h00});

    // Outputs hold through IDLE
    tick(); tick();
    check("hold_idle", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b10, 8'h00});

    // Start while busy is ignored; operand changes mid-run have no effect
    bus.a = 8'h01; bus.b = 8'h02; bus.op = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dcount = 0;
    for (int k = 1; k <= W + 3; k++) begin
      if (k == 3) begin bus.a = 8'hF0; bus.b = 8'hF0; bus.start = 1'b1; end
      if (k == 4) begin bus.start = 1'b0; bus.a = 8'hAA; bus.b = 8'h55; bus.op = 1'b1; end
      if (k == W && bus.busy !== 1'b1) dcount = dcount + 100;
      tick();
      if (bus.done === 1'b1) begin
        dcount++;
        if (k == W)
          check("busy_ign_res", {24'd0, bus.result}, 32'h03);
        else
          check("busy_ign_time", k, W);
      end
    end
    check("busy_ign_pulses", dcount, 1);
    check("busy_ign_hold", {24'd0, bus.result}, 32'h03);

    // Back-to-back: second start issued during the done cycle
    do_op(8'h35, 8'h4A, 1'b0, "b2b_first", 1'b0, 1'b0);
    bus.a = 8'h0F; bus.b = 8'h01; bus.op = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b2b_restart", {30'd0, bus.busy, bus.done}, 32'b10);
    check("b2b_hold_old", {24'd0, bus.result}, 32'h7F);
    busy_low = 0;
    for (int k = 2; k <= W + 1; k++) begin
      if (bus.busy !== 1'b1) busy_low++;
      tick();
      if (k < W + 1 && bus.done === 1'b1) busy_low++;
    end
    check("b2b_busy_gap", busy_low, 0);
    check("b2b_second_done", {30'd0, bus.busy, bus.done}, 32'b01);
    check("b2b_second_res", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b00, 8'h10});
    tick();

    // Reset mid-run aborts the operation
    bus.a = 8'h12; bus.b = 8'h34; bus.op = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {21'd0, bus.busy, bus.done, bus.cout, bus.ovf, bus.result}, 32'd0);
    dcount = 0;
    for (int k = 0; k < W; k++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dcount++;
    end
    check("rst_mid_no_done", dcount, 0);
    rst_n = 1'b1;
    do_op(8'h02, 8'h03, 1'b0, "after_rst", 1'b0, 1'b1);
    check("after_rst_abs", {24'd0, bus.result}, 32'h05);

    // Randomized operations with operand scrambling during RUN
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i), 1'b1,
            1'($urandom));
    end

    // Explicit model cross-check on a random pair against a fresh operation
    e = model(8'hC3, 8'h3D, 1'b1);
    do_op(8'hC3, 8'h3D, 1'b1, "sub_c3_3d", 1'b1, 1'b1);
    check("sub_c3_3d_model", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, e});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
